// File: rtl/mux_sel_sequencer_pkg.sv
// Shared constants and state encoding for the 8:1 mux scan sequencer.
package mux_seq_pkg;

  localparam int unsigned NSEL      = 8;
  localparam int unsigned SEL_W     = 3;
  localparam int unsigned DWELL_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mux_sel_sequencer_if.sv
// Sequencer <-> mux/environment signal bundle; master is the sequencer side.
interface mux_seq_if;
  import mux_seq_pkg::*;

  logic              start;
  logic [NSEL-1:0]   data_in;
  logic              y_in;
  logic [NSEL-1:0]   d_out;
  logic [SEL_W-1:0]  x;
  logic              busy;
  logic              done;
  logic [NSEL-1:0]   rx_word;
  logic              match;

  modport master (
    input  start, data_in, y_in,
    output d_out, x, busy, done, rx_word, match
  );

  modport slave (
    output start, data_in, y_in,
    input  d_out, x, busy, done, rx_word, match
  );

endinterface

// File: rtl/mux_sel_sequencer_dwell_counter.sv
// Dwell timer: tick marks the last clock of each select value, then wraps to zero.
module dwell_counter #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Drives a latched word onto the 8:1 mux, scans X through all selects and
// compares the looped-back Y bits against the word sent.
module mux_sel_sequencer
  import mux_seq_pkg::*;
#(
  parameter int unsigned DWELL = DWELL_DEF,
  parameter int unsigned CNT_W = 8
) (
  input  logic      clk,
  input  logic      rst,
  mux_seq_if.master bus
);

  localparam logic [SEL_W-1:0] X_LAST = SEL_W'(NSEL - 1);

  state_e           state_q;
  logic [NSEL-1:0]  d_q;
  logic [NSEL-1:0]  rx_q;
  logic [SEL_W-1:0] x_q;
  logic             busy_q;
  logic             done_q;
  logic             match_q;

  logic             cnt_clr;
  logic             cnt_en;
  logic             tick;
  logic [NSEL-1:0]  rx_d;

  assign cnt_clr = (state_q == ST_IDLE) && bus.start;
  assign cnt_en  = (state_q == ST_SCAN);

  dwell_counter #(
    .CNT_W (CNT_W),
    .DWELL (DWELL)
  ) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tick (tick)
  );

  // Captured word with the current Y merged in, so the final compare sees bit 7.
  always_comb begin
    rx_d       = rx_q;
    rx_d[x_q]  = bus.y_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      d_q     <= '0;
      rx_q    <= '0;
      x_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            d_q     <= bus.data_in;
            x_q     <= '0;
            rx_q    <= '0;
            match_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (tick) begin
            rx_q <= rx_d;
            if (x_q == X_LAST) begin
              match_q <= (rx_d == d_q);
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              x_q <= x_q + SEL_W'(1);
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.d_out   = d_q;
  assign bus.x       = x_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_word = rx_q;
  assign bus.match   = match_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Loopback bench: two sequencers (DWELL=4 and DWELL=1) each closed through a behavioural 8:1 mux.
module tb_mux_sel_sequencer;
  import mux_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  mux_seq_if bus4 ();
  mux_seq_if bus1 ();

  logic       sel1   = 1'b0;
  logic       tb_start = 1'b0;
  logic [7:0] tb_data  = 8'h00;
  logic       flt_en = 1'b0;
  logic [2:0] flt_x  = 3'd3;

  assign bus4.start   = !sel1 && tb_start;
  assign bus1.start   =  sel1 && tb_start;
  assign bus4.data_in = tb_data;
  assign bus1.data_in = tb_data;
  assign bus4.y_in    = (flt_en && bus4.x == flt_x) ? 1'b0 : bus4.d_out[bus4.x];
  assign bus1.y_in    = bus1.d_out[bus1.x];

  logic [2:0] s_x;
  logic [7:0] s_dout, s_rx;
  logic       s_busy, s_done, s_match;
  assign s_x     = sel1 ? bus1.x       : bus4.x;
  assign s_dout  = sel1 ? bus1.d_out   : bus4.d_out;
  assign s_rx    = sel1 ? bus1.rx_word : bus4.rx_word;
  assign s_busy  = sel1 ? bus1.busy    : bus4.busy;
  assign s_done  = sel1 ? bus1.done    : bus4.done;
  assign s_match = sel1 ? bus1.match   : bus4.match;

  mux_sel_sequencer #(.DWELL(4), .CNT_W(8)) dut4 (.clk(clk), .rst(rst), .bus(bus4.master));
  mux_sel_sequencer #(.DWELL(1), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1.master));

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  typedef struct {
    bit         use1;
    logic [7:0] data;
    logic [7:0] data_late;
    bit         flt;
    logic [7:0] exp_rx;
    bit         exp_match;
    bit         pokes;
  } vec_t;

  vec_t vecs[6];

  // Start a scan at the next edge E0, then check every cycle from E0 to E0+8*DWELL+2.
  task automatic run_scan(input vec_t v);
    int dw;
    int last;
    int ndone;
    int xe;
    dw    = v.use1 ? 1 : 4;
    last  = 8 * dw;
    ndone = 0;
    sel1     = v.use1;
    flt_en   = v.flt;
    tb_data  = v.data;
    tb_start = 1'b1;
    @(negedge clk);
    tb_start = 1'b0;
    tb_data  = v.data_late;
    for (int k = 0; k <= last + 2; k++) begin
      xe = k / dw;
      if (xe > 7) xe = 7;
      chk("x_step", {29'd0, s_x}, xe);
      chk("d_out_hold", {24'd0, s_dout}, {24'd0, v.data});
      chk("busy", {31'd0, s_busy}, (k <= last) ? 1 : 0);
      chk("done", {31'd0, s_done}, (k == last) ? 1 : 0);
      if (s_done) ndone++;
      tb_start = v.pokes && (k == 5 || k == last);
      if (tb_start) tb_data = ~v.data;
      @(negedge clk);
    end
    tb_start = 1'b0;
    chk("rx_word", {24'd0, s_rx}, {24'd0, v.exp_rx});
    chk("match", {31'd0, s_match}, {31'd0, v.exp_match});
    chk("done_count", ndone, 1);
    repeat (3) @(negedge clk);
    chk("idle_x_hold", {29'd0, s_x}, 7);
    chk("idle_rx_hold", {24'd0, s_rx}, {24'd0, v.exp_rx});
    flt_en = 1'b0;
  endtask

  initial begin
    vecs[0] = '{use1: 1'b0, data: 8'hAA, data_late: 8'hAA, flt: 1'b0, exp_rx: 8'hAA, exp_match: 1'b1, pokes: 1'b0};
    vecs[1] = '{use1: 1'b0, data: 8'hFF, data_late: 8'hFF, flt: 1'b1, exp_rx: 8'hF7, exp_match: 1'b0, pokes: 1'b0};
    vecs[2] = '{use1: 1'b1, data: 8'h5A, data_late: 8'h5A, flt: 1'b0, exp_rx: 8'h5A, exp_match: 1'b1, pokes: 1'b0};
    vecs[3] = '{use1: 1'b0, data: 8'h3C, data_late: 8'hC3, flt: 1'b0, exp_rx: 8'h3C, exp_match: 1'b1, pokes: 1'b0};
    vecs[4] = '{use1: 1'b0, data: 8'h66, data_late: 8'h66, flt: 1'b0, exp_rx: 8'h66, exp_match: 1'b1, pokes: 1'b1};
    vecs[5] = '{use1: 1'b1, data: 8'h81, data_late: 8'h81, flt: 1'b0, exp_rx: 8'h81, exp_match: 1'b1, pokes: 1'b1};

    #1 rst = 1'b1;
    #1;
    for (int u = 0; u < 2; u++) begin
      sel1 = (u == 1);
      #0;
      chk("rst_x", {29'd0, s_x}, 0);
      chk("rst_dout", {24'd0, s_dout}, 0);
      chk("rst_busy_done", {30'd0, s_busy, s_done}, 0);
      chk("rst_rx_match", {23'd0, s_rx, s_match}, 0);
    end
    sel1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_scan(vecs[i]);

    // Asynchronous reset in the middle of a scan, away from any clock edge.
    sel1     = 1'b0;
    tb_data  = 8'hC5;
    tb_start = 1'b1;
    @(negedge clk);
    tb_start = 1'b0;
    begin
      int n;
      n = 0;
      while (s_x != 3'd4 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("reach_x4", {31'd0, (s_x == 3'd4)}, 1);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_x", {29'd0, s_x}, 0);
    chk("arst_dout", {24'd0, s_dout}, 0);
    chk("arst_rx", {24'd0, s_rx}, 0);
    chk("arst_busy_done_match", {29'd0, s_busy, s_done, s_match}, 0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int nd;
      nd = 0;
      repeat (40) begin
        @(negedge clk);
        if (bus4.done || bus1.done) nd++;
      end
      chk("arst_no_done", nd, 0);
    end
    run_scan('{use1: 1'b0, data: 8'h0F, data_late: 8'h0F, flt: 1'b0, exp_rx: 8'h0F, exp_match: 1'b1, pokes: 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
